// File: rtl/bsg_mem_1rw_sync_mask_write_bit_fe.sv
`default_nettype none
// ============================================================================
//  Module   : bsg_mem_1rw_sync_mask_write_bit_fe
//  Purpose  : Valid/ready front end for a 1RW sync bit-masked RAM with a
//             2-entry response buffer; BSG_MEM_FE_YUMI_LOOKAHEAD_EN adds a
//             yumi_i -> ready_o path for one read per cycle sustained.
//  Revision : 1.0  initial release
// ============================================================================

`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) == 1) ? 1 : $clog2((x)))
`endif

module bsg_mem_1rw_sync_mask_write_bit_fe #(
    parameter int width_p       = 32,
    parameter int els_p         = 16,
    parameter int addr_width_lp = `BSG_SAFE_CLOG2(els_p)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,

    input  logic                     v_i,
    output logic                     ready_o,
    input  logic                     w_i,
    input  logic [addr_width_lp-1:0] addr_i,
    input  logic [width_p-1:0]       data_i,
    input  logic [width_p-1:0]       w_mask_i,

    output logic                     mem_v_o,
    output logic                     mem_w_o,
    output logic [addr_width_lp-1:0] mem_addr_o,
    output logic [width_p-1:0]       mem_data_o,
    output logic [width_p-1:0]       mem_w_mask_o,
    input  logic [width_p-1:0]       mem_data_i,

    output logic                     v_o,
    output logic [width_p-1:0]       data_o,
    input  logic                     yumi_i
);

    localparam logic [2:0] c_fifo_els = 3'd2;

    logic                 rd_inflight_q, rd_inflight_d;
    logic [1:0]           count_q, count_d;
    logic                 wptr_q, wptr_d;
    logic                 rptr_q, rptr_d;
    logic [width_p-1:0]   slot_q [2];

    logic                 w_credit;
    logic                 w_ready;
    logic                 w_accept;
    logic                 w_enq;
    logic                 w_deq;
    logic [2:0]           w_used;

    // A credit covers both buffered responses and the read still in the RAM.
    assign w_used   = {1'b0, count_q} + {2'b00, rd_inflight_q};
    assign w_credit = (w_used < c_fifo_els);

`ifdef BSG_MEM_FE_YUMI_LOOKAHEAD_EN
    assign w_ready  = ~reset_i & (w_credit | yumi_i);
`else
    assign w_ready  = ~reset_i & w_credit;
`endif

    assign ready_o      = w_ready;
    assign w_accept     = v_i & w_ready;

    assign mem_v_o      = w_accept;
    assign mem_w_o      = w_i;
    assign mem_addr_o   = addr_i;
    assign mem_data_o   = data_i;
    assign mem_w_mask_o = w_mask_i;

    assign w_enq = rd_inflight_q;
    assign w_deq = yumi_i & (count_q != 2'd0);

    always_comb begin
        rd_inflight_d = w_accept & ~w_i;
        wptr_d        = wptr_q ^ w_enq;
        rptr_d        = rptr_q ^ w_deq;
        count_d       = count_q;
        if (w_enq && !w_deq) begin
            count_d = count_q + 2'd1;
        end else if (!w_enq && w_deq) begin
            count_d = count_q - 2'd1;
        end
    end

    // Reset wins over an in-flight read, so its returning data is dropped.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_inflight_q <= 1'b0;
            count_q       <= 2'd0;
            wptr_q        <= 1'b0;
            rptr_q        <= 1'b0;
            slot_q[0]     <= '0;
            slot_q[1]     <= '0;
        end else begin
            rd_inflight_q <= rd_inflight_d;
            count_q       <= count_d;
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            if (w_enq) begin
                slot_q[wptr_q] <= mem_data_i;
            end
        end
    end

    assign v_o    = ~reset_i & (count_q != 2'd0);
    assign data_o = reset_i ? '0 : slot_q[rptr_q];

endmodule

`default_nettype wire

// File: tb/tb_bsg_mem_1rw_sync_mask_write_bit_fe.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_bsg_mem_1rw_sync_mask_write_bit_fe
//  Purpose  : Self-checking bench with RAM environment and response model.
//  Revision : 1.0  initial release
// ============================================================================

module tb_bsg_mem_1rw_sync_mask_write_bit_fe;

    localparam int W  = 32;
    localparam int E  = 16;
    localparam int AW = 4;

    logic          clk;
    logic          reset_i;
    logic          v_i, w_i, yumi_i;
    logic [AW-1:0] addr_i;
    logic [W-1:0]  data_i, w_mask_i;
    logic          ready_o, mem_v_o, mem_w_o, v_o;
    logic [AW-1:0] mem_addr_o;
    logic [W-1:0]  mem_data_o, mem_w_mask_o, mem_data_i, data_o;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        logic [W-1:0] data;
        int           avail;
    } resp_t;

    resp_t        q[$];
    logic [W-1:0] ref_mem [E];
    logic [W-1:0] ram     [E];
    logic         acc, mv, mw;

    bsg_mem_1rw_sync_mask_write_bit_fe #(
        .width_p (W),
        .els_p   (E)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .v_i          (v_i),
        .ready_o      (ready_o),
        .w_i          (w_i),
        .addr_i       (addr_i),
        .data_i       (data_i),
        .w_mask_i     (w_mask_i),
        .mem_v_o      (mem_v_o),
        .mem_w_o      (mem_w_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_w_mask_o (mem_w_mask_o),
        .mem_data_i   (mem_data_i),
        .v_o          (v_o),
        .data_o       (data_o),
        .yumi_i       (yumi_i)
    );

    always #5 clk = ~clk;

    // RAM environment; garbage on mem_data_i whenever no read was issued.
    always @(posedge clk) begin
        if (mem_v_o && mem_w_o)
            ram[mem_addr_o] <= (ram[mem_addr_o] & ~mem_w_mask_o) | (mem_data_o & mem_w_mask_o);
        if (mem_v_o && !mem_w_o)
            mem_data_i <= ram[mem_addr_o];
        else
            mem_data_i <= $urandom;
    end

    always @(negedge clk) begin
        if (reset_i === 1'b0 && yumi_i === 1'b1) begin
            checks++;
            if (v_o !== 1'b1) begin
                errors++;
                $display("FAIL yumi_without_v cyc=%0d v_o=%b required=1", cyc, v_o);
            end
        end
    end

    // One clock cycle: drive, compare at the falling edge, advance the model.
    task automatic cycle(input logic rst, input logic v, input logic w,
                         input logic [AW-1:0] a, input logic [W-1:0] d,
                         input logic [W-1:0] m, input logic yen,
                         output logic o_acc, output logic o_mv, output logic o_mw);
        logic         ev, y, er;
        logic [W-1:0] ed;
        ev = !rst && (q.size() > 0) && (q[0].avail <= cyc);
        ed = ev ? q[0].data : '0;
        y  = yen && ev;
`ifdef BSG_MEM_FE_YUMI_LOOKAHEAD_EN
        er = !rst && ((q.size() < 2) || y);
`else
        er = !rst && (q.size() < 2);
`endif
        reset_i = rst; v_i = v; w_i = w; addr_i = a;
        data_i = d; w_mask_i = m; yumi_i = y;
        #4;
        checks++;
        if (ready_o !== er) begin
            errors++;
            $display("FAIL ready_o cyc=%0d got=%b required=%b", cyc, ready_o, er);
        end
        checks++;
        if (mem_v_o !== (v && er)) begin
            errors++;
            $display("FAIL mem_v_o cyc=%0d got=%b required=%b", cyc, mem_v_o, v && er);
        end
        checks++;
        if ({mem_w_o, mem_addr_o, mem_data_o, mem_w_mask_o} !== {w, a, d, m}) begin
            errors++;
            $display("FAIL mem_req cyc=%0d got=%b/%h/%h/%h required=%b/%h/%h/%h", cyc,
                     mem_w_o, mem_addr_o, mem_data_o, mem_w_mask_o, w, a, d, m);
        end
        checks++;
        if (v_o !== ev) begin
            errors++;
            $display("FAIL v_o cyc=%0d got=%b required=%b", cyc, v_o, ev);
        end
        if (ev || rst) begin
            checks++;
            if (data_o !== ed) begin
                errors++;
                $display("FAIL data_o cyc=%0d got=%h required=%h", cyc, data_o, ed);
            end
        end
        o_acc = v_i & ready_o;
        o_mv  = mem_v_o;
        o_mw  = mem_w_o;
        if (rst) begin
            q.delete();
        end else begin
            if (y) void'(q.pop_front());
            if (v && er) begin
                if (w) ref_mem[a] = (ref_mem[a] & ~m) | (d & m);
                else   q.push_back('{data: ref_mem[a], avail: cyc + 2});
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n, input logic yen);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, '0, '0, '0, yen, acc, mv, mw);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d, input logic [W-1:0] m);
        cycle(1'b0, 1'b1, 1'b1, a, d, m, 1'b0, acc, mv, mw);
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b1, 1'b0, 4'd1, $urandom, '1, 1'b0, acc, mv, mw);
        cycle(1'b1, 1'b1, 1'b1, 4'd2, $urandom, '1, 1'b0, acc, mv, mw);
        checks++;
        if (v_o !== 1'b0 || data_o !== '0) begin
            errors++;
            $display("FAIL reset_outputs got v_o=%b data_o=%h required v_o=0 data_o=0", v_o, data_o);
        end
        idle(1, 1'b0);
    endtask

    task automatic test_masked_write();
        wr(4'd3, 32'h0, '1);
        wr(4'd3, 32'hFFFF_FFFF, 32'h0000_FFFF);
        cycle(1'b0, 1'b1, 1'b0, 4'd3, '0, '0, 1'b0, acc, mv, mw);
        checks++;
        if (v_o !== 1'b0) begin
            errors++;
            $display("FAIL latency_early got v_o=%b required=0", v_o);
        end
        idle(1, 1'b0);
        checks++;
        if (v_o !== 1'b1 || data_o !== 32'h0000_FFFF) begin
            errors++;
            $display("FAIL masked_read got v_o=%b data_o=%h required v_o=1 data_o=0000ffff", v_o, data_o);
        end
        idle(2, 1'b1);
    endtask

    task automatic test_back_to_back();
        int n;
        n = 0;
        for (int i = 0; i < 3; i++) wr(i[AW-1:0], $urandom, '1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 1'b0, i[AW-1:0], '0, '0, 1'b0, acc, mv, mw);
            n += int'(acc);
        end
        checks++;
        if (n != 2) begin
            errors++;
            $display("FAIL b2b_accepts got=%0d required=2", n);
        end
        n = 0;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 4'd2, '0, '0, 1'b0, acc, mv, mw);
            n += int'(acc);
        end
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL b2b_stall got=%0d accepts required=0", n);
        end
        idle(4, 1'b1);
    endtask

    task automatic test_stream();
        int n;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 4'($urandom_range(0, E - 1)), '0, '0, 1'b1, acc, mv, mw);
            n += int'(acc);
`ifndef BSG_MEM_FE_YUMI_LOOKAHEAD_EN
            checks++;
            if (acc !== (i % 3 != 2)) begin
                errors++;
                $display("FAIL stream_pattern i=%0d got=%b required=%b", i, acc, (i % 3 != 2));
            end
`endif
        end
        checks++;
`ifdef BSG_MEM_FE_YUMI_LOOKAHEAD_EN
        if (n != 12) begin
            errors++;
            $display("FAIL stream_accepts got=%0d required=12", n);
        end
`else
        if (n != 8) begin
            errors++;
            $display("FAIL stream_accepts got=%0d required=8", n);
        end
`endif
        idle(4, 1'b1);
    endtask

    task automatic test_reset_inflight();
        wr(4'd2, 32'hDEAD_BEEF, '1);
        cycle(1'b0, 1'b1, 1'b0, 4'd2, '0, '0, 1'b0, acc, mv, mw);
        cycle(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0, acc, mv, mw);
        cycle(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, acc, mv, mw);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (v_o !== 1'b0 || data_o !== '0) begin
                errors++;
                $display("FAIL reset_drop got v_o=%b data_o=%h required v_o=0 data_o=0", v_o, data_o);
            end
            idle(1, 1'b0);
        end
    endtask

    task automatic test_zero_mask();
        wr(4'd5, 32'hA5A5_5A5A, '1);
        wr(4'd5, 32'hFFFF_FFFF, '0);
        checks++;
        if (mv !== 1'b1 || mw !== 1'b1) begin
            errors++;
            $display("FAIL zero_mask_issue got mem_v=%b mem_w=%b required 1/1", mv, mw);
        end
        cycle(1'b0, 1'b1, 1'b0, 4'd5, '0, '0, 1'b0, acc, mv, mw);
        idle(1, 1'b0);
        checks++;
        if (data_o !== 32'hA5A5_5A5A) begin
            errors++;
            $display("FAIL zero_mask_data got=%h required=a5a55a5a", data_o);
        end
        idle(2, 1'b1);
    endtask

    task automatic test_collision();
        wr(4'd8,  32'h1111_0008, '1);
        wr(4'd9,  32'h2222_0009, '1);
        wr(4'd10, 32'h3333_000A, '1);
        cycle(1'b0, 1'b1, 1'b0, 4'd8, '0, '0, 1'b0, acc, mv, mw);
        cycle(1'b0, 1'b1, 1'b0, 4'd9, '0, '0, 1'b0, acc, mv, mw);
        idle(2, 1'b0);
        idle(1, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 4'd10, '0, '0, 1'b0, acc, mv, mw);
        idle(1, 1'b1);
        checks++;
        if (v_o !== 1'b1 || data_o !== 32'h3333_000A) begin
            errors++;
            $display("FAIL collision_head got v_o=%b data_o=%h required v_o=1 data_o=3333000a", v_o, data_o);
        end
        idle(1, 1'b1);
        checks++;
        if (v_o !== 1'b0) begin
            errors++;
            $display("FAIL collision_count got v_o=%b required=0", v_o);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cycle(1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
                  4'($urandom_range(0, E - 1)), $urandom,
                  ($urandom_range(0, 1) != 0) ? '1 : W'($urandom),
                  1'($urandom_range(0, 3) != 0), acc, mv, mw);
        end
        idle(4, 1'b1);
    endtask

    initial begin
        clk = 1'b0;
        reset_i = 1'b1; v_i = 1'b0; w_i = 1'b0; yumi_i = 1'b0;
        addr_i = '0; data_i = '0; w_mask_i = '0;
        for (int i = 0; i < E; i++) begin
            ram[i]     = '0;
            ref_mem[i] = '0;
        end
        @(posedge clk);
        #1;
        test_reset();
        test_masked_write();
        test_back_to_back();
        test_stream();
        test_reset_inflight();
        test_zero_mask();
        test_collision();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
